// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester data memory arbiter.
package mem_arb_pkg;

    // Byte size of the attached data memory unless overridden.
    localparam int ADDR_LIMIT_DEFAULT = 256;

    // Arbiter FSM. The encoding is visible on the fsm_state debug output.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Requester identity. Bit index in the request/grant vectors matches the value.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the
// requester that was not granted last. Purely combinational.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output logic [1:0] grant
);

    // One-hot grant (bit 0 = a, bit 1 = b), zero when nobody asks.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == REQ_A) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates two requesters onto one single-port data memory.
//
// Handshake: a requester raises x_req with x_we/x_addr/x_wdata and holds them
// stable until x_gnt is seen high in the same cycle (x_gnt is combinational,
// only in IDLE). After x_gnt it may drop or change them. Completion is a
// one-cycle x_done; x_err qualifies it (1 = rejected, no memory access made).
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_done,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_done,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  fsm_state
);

    // Highest word-aligned byte address that still fits in memory.
    localparam logic [31:0] LAST_WORD = 32'(ADDR_LIMIT - 4);

    state_t      state, state_nxt;
    req_id_t     last, owner;
    logic [1:0]  pick;
    logic        grant_any;
    logic        sel_we, sel_bad;
    logic [31:0] sel_addr, sel_wdata;
    logic        lat_we, lat_bad;
    logic        resp_read;
    logic [31:0] a_rdata_q, b_rdata_q;

    rr_arbiter2 u_rr (
        .req   ({b_req, a_req}),
        .last  (last),
        .grant (pick)
    );

    // Route the picked requester's fields and decide whether it is rejected.
    always_comb begin
        sel_we    = pick[1] ? b_we    : a_we;
        sel_addr  = pick[1] ? b_addr  : a_addr;
        sel_wdata = pick[1] ? b_wdata : a_wdata;
        sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and grant pulses; rejected grants skip ACCESS.
    always_comb begin
        state_nxt = state;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick != 2'b00) begin
                    a_gnt     = pick[0];
                    b_gnt     = pick[1];
                    state_nxt = sel_bad ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign grant_any = a_gnt | b_gnt;

    // Latch the granted request and raise exactly one strobe for the ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= REQ_B;
            owner     <= REQ_A;
            lat_we    <= 1'b0;
            lat_bad   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (grant_any) begin
                last      <= b_gnt ? REQ_B : REQ_A;
                owner     <= b_gnt ? REQ_B : REQ_A;
                lat_we    <= sel_we;
                lat_bad   <= sel_bad;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_read  <= !sel_bad && !sel_we;
                mem_write <= !sel_bad && sel_we;
            end
        end
    end

    // A successful read completes in RESP, where the memory's registered data is valid.
    assign resp_read = (state == S_RESP) && !lat_bad && !lat_we;

    // Hold each requester's last successful read result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_q <= 32'd0;
            b_rdata_q <= 32'd0;
        end else if (resp_read) begin
            if (owner == REQ_A) a_rdata_q <= mem_rdata;
            else                b_rdata_q <= mem_rdata;
        end
    end

    assign a_done    = (state == S_RESP) && (owner == REQ_A);
    assign b_done    = (state == S_RESP) && (owner == REQ_B);
    assign a_err     = a_done && lat_bad;
    assign b_err     = b_done && lat_bad;
    // Bypass so the read result is already visible in the done cycle.
    assign a_rdata   = (resp_read && owner == REQ_A) ? mem_rdata : a_rdata_q;
    assign b_rdata   = (resp_read && owner == REQ_B) ? mem_rdata : b_rdata_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small registered memory model.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [31:0] a_addr = 32'd0, a_wdata = 32'd0;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [31:0] b_addr = 32'd0, b_wdata = 32'd0;
    logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata = 32'd0;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:63] = '{default: 32'd0};

    data_mem_arbiter #(.ADDR_LIMIT(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_done    (a_done),
        .a_err     (a_err),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_done    (b_done),
        .b_err     (b_err),
        .b_rdata   (b_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .fsm_state (fsm_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Memory with registered read data.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[7:2]];
    end

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        checks++; if ({a_gnt, b_gnt, a_done, b_done, a_err, b_err, mem_read, mem_write} !== 8'h00) begin errors++; $display("FAIL rst_pulses: got %b want 00000000", {a_gnt, b_gnt, a_done, b_done, a_err, b_err, mem_read, mem_write}); end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem_bus: addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); end
        checks++; if (a_rdata !== 32'd0 || b_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: a=%h b=%h want 0/0", a_rdata, b_rdata); end
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", fsm_state); end
        cyc();
    endtask

    task automatic test_contention();
        logic [1:0] gnt_exp, stb_exp, done_exp;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd4;
        for (int k = 0; k < 12; k++) begin
            gnt_exp  = (k == 0 || k == 6) ? 2'b10 : (k == 3 || k == 9) ? 2'b01 : 2'b00;
            stb_exp  = (k == 1 || k == 4 || k == 7 || k == 10) ? 2'b10 : 2'b00;
            done_exp = (k == 2 || k == 8) ? 2'b10 : (k == 5 || k == 11) ? 2'b01 : 2'b00;
            @(negedge clk);
            checks++; if ({a_gnt, b_gnt} !== gnt_exp) begin errors++; $display("FAIL rr_gnt[%0d]: a/b gnt=%b want %b", k, {a_gnt, b_gnt}, gnt_exp); end
            checks++; if ({mem_read, mem_write} !== stb_exp) begin errors++; $display("FAIL rr_strobe[%0d]: rd/wr=%b want %b", k, {mem_read, mem_write}, stb_exp); end
            checks++; if ({a_done, b_done} !== done_exp) begin errors++; $display("FAIL rr_done[%0d]: a/b done=%b want %b", k, {a_done, b_done}, done_exp); end
            cyc();
            if (k == 9) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
        end
    endtask

    task automatic test_write_read();
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd20; a_wdata = 32'h0000_0032;
        @(negedge clk);
        checks++; if ({a_gnt, b_gnt} !== 2'b10) begin errors++; $display("FAIL wr_gnt: a/b gnt=%b want 10", {a_gnt, b_gnt}); end
        cyc();
        a_req = 1'b0;
        @(negedge clk);
        checks++; if ({mem_read, mem_write} !== 2'b01) begin errors++; $display("FAIL wr_strobe: rd/wr=%b want 01", {mem_read, mem_write}); end
        checks++; if (mem_addr !== 32'd20 || mem_wdata !== 32'h32) begin errors++; $display("FAIL wr_bus: addr=%h wdata=%h want 14/32", mem_addr, mem_wdata); end
        cyc();
        @(negedge clk);
        checks++; if ({a_done, a_err, b_done} !== 3'b100) begin errors++; $display("FAIL wr_done: done/err/bdone=%b want 100", {a_done, a_err, b_done}); end
        checks++; if (a_rdata !== 32'd0) begin errors++; $display("FAIL wr_rdata_kept: got %h want 0", a_rdata); end
        cyc();
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd20; a_wdata = 32'd0;
        @(negedge clk);
        checks++; if ({a_gnt, b_gnt} !== 2'b10) begin errors++; $display("FAIL rd_gnt: a/b gnt=%b want 10", {a_gnt, b_gnt}); end
        cyc();
        a_req = 1'b0;
        @(negedge clk);
        checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("FAIL rd_strobe: rd/wr=%b want 10", {mem_read, mem_write}); end
        cyc();
        @(negedge clk);
        checks++; if ({a_done, a_err} !== 2'b10) begin errors++; $display("FAIL rd_done: done/err=%b want 10", {a_done, a_err}); end
        checks++; if (a_rdata !== 32'h32) begin errors++; $display("FAIL rd_data: got %h want 00000032", a_rdata); end
        cyc();
        @(negedge clk);
        checks++; if (a_rdata !== 32'h32) begin errors++; $display("FAIL rd_data_hold: got %h want 00000032", a_rdata); end
        checks++; if ({mem_read, mem_write, a_done} !== 3'b000 || mem_addr !== 32'd20) begin errors++; $display("FAIL rd_idle: rd/wr/done=%b addr=%h want 000/14", {mem_read, mem_write, a_done}, mem_addr); end
        cyc();
    endtask

    task automatic test_misaligned();
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd20;
        @(negedge clk);
        checks++; if ({a_gnt, b_gnt} !== 2'b01) begin errors++; $display("FAIL mis_prime_gnt: a/b gnt=%b want 01", {a_gnt, b_gnt}); end
        cyc();
        b_req = 1'b0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        checks++; if ({b_done, b_err} !== 2'b10 || b_rdata !== 32'h32) begin errors++; $display("FAIL mis_prime: done/err=%b rdata=%h want 10/00000032", {b_done, b_err}, b_rdata); end
        cyc();
        b_req = 1'b1; b_addr = 32'h15;
        @(negedge clk);
        checks++; if ({a_gnt, b_gnt} !== 2'b01) begin errors++; $display("FAIL mis_gnt: a/b gnt=%b want 01", {a_gnt, b_gnt}); end
        cyc();
        b_addr = 32'd20;
        @(negedge clk);
        checks++; if ({b_done, b_err, a_done} !== 3'b110) begin errors++; $display("FAIL mis_err: done/err/adone=%b want 110", {b_done, b_err, a_done}); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL mis_strobe: rd/wr=%b want 00", {mem_read, mem_write}); end
        checks++; if (b_rdata !== 32'h32) begin errors++; $display("FAIL mis_rdata_kept: got %h want 00000032", b_rdata); end
        checks++; if (fsm_state !== 2'd2) begin errors++; $display("FAIL mis_state: got %0d want 2", fsm_state); end
        cyc();
        @(negedge clk);
        checks++; if ({a_gnt, b_gnt, b_done} !== 3'b010) begin errors++; $display("FAIL mis_b2b_gnt: a/b gnt/bdone=%b want 010", {a_gnt, b_gnt, b_done}); end
        cyc();
        b_req = 1'b0;
        @(negedge clk);
        checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("FAIL mis_b2b_strobe: rd/wr=%b want 10", {mem_read, mem_write}); end
        cyc();
        @(negedge clk);
        checks++; if ({b_done, b_err} !== 2'b10 || b_rdata !== 32'h32) begin errors++; $display("FAIL mis_b2b_done: done/err=%b rdata=%h want 10/00000032", {b_done, b_err}, b_rdata); end
        cyc();
    endtask

    task automatic test_range();
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd253; a_wdata = 32'hA5A5_0001;
        @(negedge clk);
        cyc();
        a_req = 1'b0;
        @(negedge clk);
        checks++; if ({a_done, a_err, mem_read, mem_write} !== 4'b1100) begin errors++; $display("FAIL rng_253: done/err/rd/wr=%b want 1100", {a_done, a_err, mem_read, mem_write}); end
        checks++; if (a_rdata !== 32'h32) begin errors++; $display("FAIL rng_rdata_kept: got %h want 00000032", a_rdata); end
        cyc();
        a_req = 1'b1; a_addr = 32'd256;
        @(negedge clk);
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL rng_256_gnt: got %b want 1", a_gnt); end
        cyc();
        a_req = 1'b0;
        @(negedge clk);
        checks++; if ({a_done, a_err, mem_read, mem_write} !== 4'b1100) begin errors++; $display("FAIL rng_256: done/err/rd/wr=%b want 1100", {a_done, a_err, mem_read, mem_write}); end
        cyc();
        a_req = 1'b1; a_addr = 32'd252;
        @(negedge clk);
        cyc();
        a_req = 1'b0;
        @(negedge clk);
        checks++; if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 32'd252) begin errors++; $display("FAIL rng_252_wr: rd/wr=%b addr=%h want 01/fc", {mem_read, mem_write}, mem_addr); end
        cyc();
        @(negedge clk);
        checks++; if ({a_done, a_err} !== 2'b10) begin errors++; $display("FAIL rng_252_done: done/err=%b want 10", {a_done, a_err}); end
        cyc();
        a_req = 1'b1; a_we = 1'b0;
        @(negedge clk);
        cyc();
        a_req = 1'b0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        checks++; if ({a_done, a_err} !== 2'b10 || a_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL rng_252_rd: done/err=%b rdata=%h want 10/a5a50001", {a_done, a_err}, a_rdata); end
        cyc();
    endtask

    task automatic test_reset_mid();
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd252;
        @(negedge clk);
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b want 1", a_gnt); end
        cyc();
        a_req = 1'b0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b1 || fsm_state !== 2'd1) begin errors++; $display("FAIL rmid_access: rd=%b state=%0d want 1/1", mem_read, fsm_state); end
        #1 rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({a_done, b_done, mem_read, mem_write} !== 4'b0000 || fsm_state !== 2'd0) begin errors++; $display("FAIL rmid_abort: done a/b rd/wr=%b state=%0d want 0000/0", {a_done, b_done, mem_read, mem_write}, fsm_state); end
        checks++; if (a_rdata !== 32'd0) begin errors++; $display("FAIL rmid_rdata: got %h want 0", a_rdata); end
        cyc();
        @(negedge clk);
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rmid_late_done: got %b want 0", a_done); end
        cyc();
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd252;
        @(negedge clk);
        checks++; if ({a_gnt, b_gnt} !== 2'b01) begin errors++; $display("FAIL rmid_b_gnt: a/b gnt=%b want 01", {a_gnt, b_gnt}); end
        cyc();
        b_req = 1'b0;
        @(negedge clk);
        checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("FAIL rmid_b_strobe: rd/wr=%b want 10", {mem_read, mem_write}); end
        cyc();
        @(negedge clk);
        checks++; if ({b_done, b_err, a_done} !== 3'b100 || b_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL rmid_b_done: done/err/adone=%b rdata=%h want 100/a5a50001", {b_done, b_err, a_done}, b_rdata); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_write_read();
        test_misaligned();
        test_range();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_LIMIT, default 256, SHALL give the byte size of the attached data memory.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 x_req  in  1  access request, one per requester x = a, b.
REQ-005 x_we  in  1  access type: 1 = write, 0 = read.
REQ-006 x_addr  in  32  byte address, big-endian word.
REQ-007 x_wdata  in  32  write data.
REQ-008 x_gnt  out  1  one-cycle pulse marking acceptance of the request.
REQ-009 x_done  out  1  one-cycle completion pulse.
REQ-010 x_err  out  1  qualifies x_done; high means the access was rejected.
REQ-011 x_rdata  out  32  read result, held until the next successful read by x.
REQ-012 mem_addr, mem_wdata  out  32 each  drive the memory address and data inputs.
REQ-013 mem_read, mem_write  out  1 each  registered memory strobes.
REQ-014 mem_rdata  in  32  memory output, registered by the memory on the clk edge that samples mem_read.

Function
REQ-015 The block SHALL run an FSM with states IDLE, ACCESS and RESP.
REQ-016 In IDLE with at least one x_req high, the block SHALL pulse the selected x_gnt combinationally and latch x_we, x_addr and x_wdata at that edge.
REQ-017 A lone request SHALL be granted; when a_req and b_req are high together, the requester not granted last SHALL win.
REQ-018 A valid request SHALL follow this timeline: gnt in cycle N; ACCESS in N+1, with exactly one strobe high for one cycle; RESP in N+2, with x_done high, x_err low and x_rdata = mem_rdata for a read.
REQ-019 A request SHALL be rejected when x_addr[1:0] != 0 or x_addr > ADDR_LIMIT-4.
REQ-020 For a rejected request, the FSM SHALL go IDLE->RESP, leave both strobes low, and pulse x_done with x_err high in N+1, leaving x_rdata unchanged.
REQ-021 A write SHALL leave x_rdata unchanged.
REQ-022 mem_read and mem_write SHALL never be high together, and SHALL be low outside ACCESS.
REQ-023 mem_addr and mem_wdata SHALL hold their last latched values outside ACCESS.
REQ-024 RESP SHALL return to IDLE in the next cycle; back-to-back grants SHALL therefore be at least 3 cycles apart, or 2 after a rejection.
REQ-025 Requests arriving outside IDLE SHALL wait; each requester SHALL hold req and its fields stable until gnt and may drop req after gnt.
REQ-026 At most one x_done SHALL be high in any cycle, and it SHALL belong to the requester last granted.
REQ-027 Round-robin state SHALL update only on a grant, including rejected grants.

Reset
REQ-028 When rst is high at an edge, the block SHALL go to IDLE with all gnt, done, err and strobe outputs at 0, mem_addr, mem_wdata and both x_rdata at 0, and last-granted set to b.
REQ-029 Reset during ACCESS SHALL NOT retract a strobe already sampled by memory at that edge; no x_done SHALL follow, and the aborted access SHALL be silently dropped.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the FSM state enum, the requester-id type and the ADDR_LIMIT default.
REQ-031 The two-way round-robin picker SHALL be a sub-module named rr_arbiter2 (inputs req[1:0] and last; output grant one-hot).

Verification
REQ-032 Write then read: a write of 0x00000032 to address 20, then a read from address 20, SHALL give mem_write high in N+1 and a_done in N+2; a_rdata SHALL then read 0x00000032.
REQ-033 Contention: a_req and b_req raised in the same cycle after reset SHALL be served a first; with both held, grants SHALL alternate b, a, b.
REQ-034 Misaligned access: b read at address 0x15 SHALL give b_done with b_err high one cycle after b_gnt, no strobe, and b_rdata unchanged.
REQ-035 Out-of-range access: a write at address 253 with ADDR_LIMIT=256 SHALL be rejected, and address 252 SHALL be accepted.
REQ-036 Reset mid-operation: rst pulsed in the ACCESS cycle of an a read SHALL produce no a_done, return the FSM to IDLE, and serve a following b request normally.
